// File: rtl/niveles_multicanal.sv
// niveles_multicanal
// Multi-channel need-level manager for the virtual-pet core. The core keeps
// NUM_CANALES independent levels, for example hunger, sleep and fun.
//
// Each level:
//   - decays by one step every P active cycles, where P is PERIODO or
//     PERIODO_TEST depending on modo_test
//   - is raised by PASO_SUBIDA on each synchronised, edge-detected press of
//     its button
//
// A global health FSM summarises all channels for the display and sound
// blocks.
//
// Ports:
//   clk        system clock, all state on rising edge
//   B_reset    asynchronous active-high reset
//   activo     1 = decay timers and FIN counter run, 0 = they hold
//   modo_test  1 = short decay period (PERIODO_TEST)
//   sube       raw asynchronous raise buttons, bit i -> channel i
//   nivel      packed levels, channel i at [i*ANCHO_NIVEL +: ANCHO_NIVEL]
//   alerta     bit i set when level i <= UMBRAL_ALERTA (no lag vs nivel)
//   estado     registered health state: 0 NORMAL, 1 ALERTA, 2 CRITICO, 3 FIN
module niveles_multicanal #(
  parameter int NUM_CANALES   = 3,
  parameter int ANCHO_NIVEL   = 2,
  parameter int PERIODO       = 65,
  parameter int PERIODO_TEST  = 5,
  parameter int PASO_SUBIDA   = 1,
  parameter int UMBRAL_ALERTA = 1,
  parameter int LIMITE_FIN    = 130
) (
  input  logic                               clk,
  input  logic                               B_reset,
  input  logic                               activo,
  input  logic                               modo_test,
  input  logic [NUM_CANALES-1:0]             sube,
  output logic [NUM_CANALES*ANCHO_NIVEL-1:0] nivel,
  output logic [NUM_CANALES-1:0]             alerta,
  output logic [1:0]                         estado
);

  localparam int NIVEL_MAX = (1 << ANCHO_NIVEL) - 1;
  localparam int PMAX      = (PERIODO > PERIODO_TEST) ? PERIODO : PERIODO_TEST;
  localparam int TW        = $clog2(PMAX + 1);
  localparam int FW        = $clog2(LIMITE_FIN + 1);

  localparam logic [TW-1:0]          P_NORMAL_M1 = TW'(PERIODO - 1);
  localparam logic [TW-1:0]          P_TEST_M1   = TW'(PERIODO_TEST - 1);
  localparam logic [ANCHO_NIVEL:0]   PASO_W      = (ANCHO_NIVEL + 1)'(PASO_SUBIDA);
  localparam logic [ANCHO_NIVEL:0]   MAX_W       = (ANCHO_NIVEL + 1)'(NIVEL_MAX);
  localparam logic [ANCHO_NIVEL:0]   UMBRAL_W    = (ANCHO_NIVEL + 1)'(UMBRAL_ALERTA);
  localparam logic [ANCHO_NIVEL-1:0] NIVEL_MAX_N = ANCHO_NIVEL'(NIVEL_MAX);
  localparam logic [FW-1:0]          LIM_W       = FW'(LIMITE_FIN);

  typedef enum logic [1:0] {
    NORMAL  = 2'd0,
    ALERTA  = 2'd1,
    CRITICO = 2'd2,
    FIN     = 2'd3
  } estado_t;

  estado_t estado_q;
  logic [NUM_CANALES-1:0] sync1_q;
  logic [NUM_CANALES-1:0] sync2_q;
  logic [NUM_CANALES-1:0] prev_q;
  logic [NUM_CANALES-1:0] press;
  logic [NUM_CANALES-1:0] en_cero;
  logic [FW-1:0]          fin_cnt_q;
  logic [TW-1:0]          periodo_m1;
  logic                   en_fin;
  logic                   alguno_cero;
  logic                   alguna_alerta;

  assign en_fin        = (estado_q == FIN);
  assign periodo_m1    = modo_test ? P_TEST_M1 : P_NORMAL_M1;
  assign alguno_cero   = |en_cero;
  assign alguna_alerta = |alerta;

  // Flops reset to 1 so that a button already held at reset release
  // looks like "still high" rather than a fresh rising edge.
  always_ff @(posedge clk or posedge B_reset) begin
    if (B_reset) begin
      sync1_q <= '1;
      sync2_q <= '1;
      prev_q  <= '1;
    end else begin
      sync1_q <= sube;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Presses are dropped once the pet has reached FIN.
  assign press = sync2_q & ~prev_q & {NUM_CANALES{~en_fin}};

  for (genvar i = 0; i < NUM_CANALES; i++) begin : g_canal
    logic [ANCHO_NIVEL-1:0] nivel_q;
    logic [TW-1:0]          timer_q;
    logic [ANCHO_NIVEL:0]   suma;

    assign suma = {1'b0, nivel_q} + PASO_W;

    // A press wins over a simultaneous expiry.
    // Timers run on >= so that switching to a shorter period mid-count
    // expires on the next active cycle instead of wrapping around.
    always_ff @(posedge clk or posedge B_reset) begin
      if (B_reset) begin
        nivel_q <= NIVEL_MAX_N;
        timer_q <= '0;
      end else if (!en_fin) begin
        if (press[i]) begin
          nivel_q <= (suma > MAX_W) ? NIVEL_MAX_N : suma[ANCHO_NIVEL-1:0];
          timer_q <= '0;
        end else if (activo) begin
          if (timer_q >= periodo_m1) begin
            timer_q <= '0;
            if (nivel_q != '0) begin
              nivel_q <= nivel_q - 1'b1;
            end
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
      end
    end

    assign nivel[i*ANCHO_NIVEL +: ANCHO_NIVEL] = nivel_q;
    assign en_cero[i] = (nivel_q == '0);
    assign alerta[i]  = ({1'b0, nivel_q} <= UMBRAL_W);
  end

  // Counts active cycles spent with at least one channel empty.
  // Leaving the empty condition always restarts the count, even while paused.
  always_ff @(posedge clk or posedge B_reset) begin
    if (B_reset) begin
      fin_cnt_q <= '0;
    end else if (!en_fin) begin
      if (!alguno_cero) begin
        fin_cnt_q <= '0;
      end else if (activo && fin_cnt_q != LIM_W) begin
        fin_cnt_q <= fin_cnt_q + 1'b1;
      end
    end
  end

  // Health FSM. FIN is terminal until reset.
  always_ff @(posedge clk or posedge B_reset) begin
    if (B_reset) begin
      estado_q <= NORMAL;
    end else if (!en_fin) begin
      if (fin_cnt_q == LIM_W) begin
        estado_q <= FIN;
      end else if (alguno_cero) begin
        estado_q <= CRITICO;
      end else if (alguna_alerta) begin
        estado_q <= ALERTA;
      end else begin
        estado_q <= NORMAL;
      end
    end
  end

  assign estado = estado_q;

endmodule

// File: tb/tb_niveles_multicanal.sv
// tb_niveles_multicanal
// Directed bench for niveles_multicanal with default parameters
// (3 channels, 2-bit levels, periods 65/5, FIN after 130 cycles).
// Edges are counted from the first rising edge after reset release.
// Outputs are sampled 1 time unit after the edge.
module tb_niveles_multicanal;

  logic       clk;
  logic       B_reset;
  logic       activo;
  logic       modo_test;
  logic [2:0] sube;
  logic [5:0] nivel;
  logic [2:0] alerta;
  logic [1:0] estado;

  int n_checks;
  int n_fail;

  niveles_multicanal #(
    .NUM_CANALES   (3),
    .ANCHO_NIVEL   (2),
    .PERIODO       (65),
    .PERIODO_TEST  (5),
    .PASO_SUBIDA   (1),
    .UMBRAL_ALERTA (1),
    .LIMITE_FIN    (130)
  ) dut (
    .clk       (clk),
    .B_reset   (B_reset),
    .activo    (activo),
    .modo_test (modo_test),
    .sube      (sube),
    .nivel     (nivel),
    .alerta    (alerta),
    .estado    (estado)
  );

  // 10-unit clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Drive the raw button vector.
  task automatic applyStimulus(input logic [2:0] s);
    sube = s;
  endtask

  // Advance n rising edges and land just after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Release reset just after an edge so the next edge is edge 1.
  task automatic releaseReset();
    @(posedge clk);
    #1;
    B_reset = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    B_reset   = 1'b1;
    activo    = 1'b1;
    modo_test = 1'b0;
    sube      = 3'b000;

    // Reset values, sampled before any clock edge.
    #2;
    checkOutput("rst_nivel", 32'(nivel), 32'h3F);
    checkOutput("rst_estado", 32'(estado), 32'd0);
    checkOutput("rst_alerta", 32'(alerta), 32'd0);

    // Saturation: a press on channel 0 while it is at 3 keeps it at 3.
    releaseReset();
    applyStimulus(3'b001);
    tick(4);
    applyStimulus(3'b000);
    tick(2);
    checkOutput("sat_nivel", 32'(nivel), 32'h3F);

    // Normal-mode decay, every channel starts at 3.
    B_reset = 1'b1;
    tick(1);
    releaseReset();
    tick(64);
    checkOutput("dec_e64_nivel", 32'(nivel), 32'h3F);
    checkOutput("dec_e64_estado", 32'(estado), 32'd0);
    tick(1);
    checkOutput("dec_e65_nivel", 32'(nivel), 32'h2A);
    checkOutput("dec_e65_alerta", 32'(alerta), 32'd0);
    tick(65);
    checkOutput("dec_e130_nivel", 32'(nivel), 32'h15);
    checkOutput("dec_e130_alerta", 32'(alerta), 32'h7);
    checkOutput("dec_e130_estado", 32'(estado), 32'd0);
    tick(1);
    checkOutput("dec_e131_estado", 32'(estado), 32'd1);
    tick(64);
    checkOutput("dec_e195_nivel", 32'(nivel), 32'h00);
    checkOutput("dec_e195_estado", 32'(estado), 32'd1);
    tick(1);
    checkOutput("dec_e196_estado", 32'(estado), 32'd2);

    // FIN entry: levels reached 0 at edge 195, so FIN lands at edge 326.
    tick(129);
    checkOutput("fin_e325_estado", 32'(estado), 32'd2);
    tick(1);
    checkOutput("fin_e326_estado", 32'(estado), 32'd3);

    // Presses are ignored in FIN.
    applyStimulus(3'b111);
    tick(4);
    applyStimulus(3'b000);
    tick(3);
    checkOutput("fin_press_nivel", 32'(nivel), 32'h00);
    checkOutput("fin_press_estado", 32'(estado), 32'd3);

    // Async reset mid-cycle, with no clock edge in between.
    #2;
    B_reset = 1'b1;
    #1;
    checkOutput("arst_nivel", 32'(nivel), 32'h3F);
    checkOutput("arst_estado", 32'(estado), 32'd0);

    // Test mode; buttons held through reset release must not count.
    modo_test = 1'b1;
    applyStimulus(3'b111);
    tick(2);
    releaseReset();
    tick(4);
    checkOutput("hold_e4_nivel", 32'(nivel), 32'h3F);
    tick(1);
    checkOutput("hold_e5_nivel", 32'(nivel), 32'h2A);
    tick(5);
    checkOutput("tm_e10_nivel", 32'(nivel), 32'h15);
    checkOutput("tm_e10_alerta", 32'(alerta), 32'h7);

    // Release buttons, then press channel 0 so it collides with its expiry.
    // The press is sampled at edge 13 and lands at edge 15.
    applyStimulus(3'b000);
    tick(2);
    applyStimulus(3'b001);
    tick(2);
    checkOutput("col_e14_nivel", 32'(nivel), 32'h15);
    applyStimulus(3'b000);
    tick(1);
    checkOutput("col_e15_nivel", 32'(nivel), 32'h02);
    checkOutput("col_e15_alerta", 32'(alerta), 32'h6);
    tick(1);
    checkOutput("col_e16_estado", 32'(estado), 32'd2);
    tick(3);
    checkOutput("col_e19_nivel", 32'(nivel), 32'h02);
    tick(1);
    checkOutput("col_e20_nivel", 32'(nivel), 32'h01);

    // Hold: activo=0 from edge 21 through edge 40.
    // Channel 2 is pressed during the hold and lands at edge 25.
    activo = 1'b0;
    tick(2);
    applyStimulus(3'b100);
    tick(2);
    applyStimulus(3'b000);
    tick(16);
    checkOutput("hold_e40_nivel", 32'(nivel), 32'h11);
    checkOutput("hold_e40_estado", 32'(estado), 32'd2);

    // Resume. Channels 0 and 2 both have timer 0 and expire at edge 45.
    activo = 1'b1;
    tick(4);
    checkOutput("res_e44_nivel", 32'(nivel), 32'h11);
    tick(1);
    checkOutput("res_e45_nivel", 32'(nivel), 32'h00);

    // FIN counter: 5 counts at edges 16..20, held during the pause,
    // 130 at edge 165, so FIN at edge 166.
    tick(120);
    checkOutput("fin2_e165_estado", 32'(estado), 32'd2);
    tick(1);
    checkOutput("fin2_e166_estado", 32'(estado), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule
